// File: rtl/gpu_pkg.sv
// Shared types and default widths for the GPU compute core.
// Scheduler state encoding, fetcher FSM encoding and default program-memory
// widths live here so every core block agrees on them.
package gpu_pkg;

  // Default program-memory geometry: 8-bit PC, 16-bit instruction word.
  localparam int PROGRAM_MEM_ADDR_BITS_DEFAULT = 8;
  localparam int PROGRAM_MEM_DATA_BITS_DEFAULT = 16;

  // Core scheduler state, broadcast to every stage of the core.
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  // Fetcher FSM state. Encodings 011..111 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/fetch_cache.sv
// Single-entry instruction cache: one tag, one data word, one valid bit.
// Lookup is combinational against the tag; fill happens on the clock edge
// that completes a memory fetch. There is no invalidate: program memory is
// read-only while a kernel runs, so only reset clears the entry.
module fetch_cache #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data
);

  logic [ADDR_BITS-1:0] tag_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  // Entry storage: cleared by reset, overwritten by every completed fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fill_en) begin
      tag_q   <= fill_addr;
      data_q  <= fill_data;
      valid_q <= 1'b1;
    end
  end

  // Hit when the entry is valid and holds the requested address.
  always_comb begin
    hit      = valid_q && (lookup_addr == tag_q);
    hit_data = data_q;
  end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage of the GPU compute core.
// Reads the instruction at current_pc from program memory when the scheduler
// enters FETCH and holds it on `instruction` for the decoder.
// Optional feature macro: FETCHER_CACHE_EN adds a single-entry instruction
// cache (fetch_cache) that turns a repeat fetch of the same PC into a
// 1-cycle hit with no memory request.
//
// Read handshake towards the program-memory controller:
//   mem_read_valid/mem_read_address are registered. Once valid is raised the
//   address is held stable and valid stays high until a cycle in which
//   mem_read_ready=1 is sampled on an enabled edge; mem_read_data is taken in
//   that same cycle and valid drops on that edge. A request is never
//   withdrawn except by reset. ready is ignored whenever no request is open.
module fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT,
  parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  fetcher_state_t                   state_q;
  fetcher_state_t                   state_d;
  logic                             valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_d;

  logic                             cache_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

`ifdef FETCHER_CACHE_EN
  logic fill_en;

  // A fill is the same event as a memory fetch completing on an enabled edge.
  assign fill_en = enable && (state_q == FETCHER_FETCHING) && mem_read_ready;

  fetch_cache #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS)
  ) u_fetch_cache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (fill_en),
    .fill_addr   (mem_read_address),
    .fill_data   (mem_read_data)
  );
`else
  // Without the cache every FETCH misses and goes to memory.
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Next-state and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_d = state_q;
    valid_d = mem_read_valid;
    addr_d  = mem_read_address;
    instr_d = instruction;
    case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instr_d = cache_data;
            state_d = FETCHER_FETCHED;
          end else begin
            // Address is latched here so later PC changes cannot disturb it.
            valid_d = 1'b1;
            addr_d  = current_pc;
            state_d = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        // Completes regardless of where the scheduler has moved on to.
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          state_d = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = FETCHER_IDLE;
        end
      end
      default: begin
        // Illegal encoding: recover to IDLE with no request open.
        valid_d = 1'b0;
        state_d = FETCHER_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over enable, enable=0 freezes all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else if (enable) begin
      state_q          <= state_d;
      mem_read_valid   <= valid_d;
      mem_read_address <= addr_d;
      instruction      <= instr_d;
    end
  end

  assign fetcher_state = state_q;

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of a GPU compute core: issues a read for the instruction at `current_pc` to program memory and hands the returned word to the decoder. The core scheduler drives it through `core_state`. It sits directly upstream of the decoder and the `pc` block; `pc` later consumes the decoded fields derived from this instruction. Memory access uses a valid/ready read handshake towards the program-memory controller.

## Interface

Parameters:
- `PROGRAM_MEM_ADDR_BITS`, default 8, program memory address width (width of the PC).
- `PROGRAM_MEM_DATA_BITS`, default 16, instruction word width.

Ports:
- `clk`, input, 1: core clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low (0 = reset), sampled on the `clk` rising edge.
- `enable`, input, 1: core enable; when 0, all registers hold.
- `core_state`, input, 3: scheduler state. IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- `current_pc`, input, `PROGRAM_MEM_ADDR_BITS`: address of the instruction to fetch.
- `mem_read_valid`, output, 1: read request valid; registered.
- `mem_read_address`, output, `PROGRAM_MEM_ADDR_BITS`: request address; registered.
- `mem_read_ready`, input, 1: memory response strobe; `mem_read_data` is valid in the same cycle.
- `mem_read_data`, input, `PROGRAM_MEM_DATA_BITS`: returned instruction word.
- `fetcher_state`, output, 3: FSM state, watched by the scheduler.
- `instruction`, output, `PROGRAM_MEM_DATA_BITS`: last fetched instruction; registered.

## Operation

FSM states are IDLE=000, FETCHING=001 and FETCHED=010. States 011–111 are illegal; if one occurs, the FSM goes to IDLE on the next enabled edge.

- **IDLE**
  - When `core_state`==FETCH: set `mem_read_valid`←1, set `mem_read_address`←`current_pc`, go to FETCHING.
  - Otherwise: stay in IDLE.
- **FETCHING**
  - `mem_read_valid` and `mem_read_address` stay stable until `mem_read_ready`=1.
  - On `mem_read_ready`=1: set `instruction`←`mem_read_data`, set `mem_read_valid`←0, go to FETCHED.
- **FETCHED**
  - When `core_state`==DECODE: go to IDLE.
  - `instruction` keeps its value until the next fetch completes.

Boundary rules:
- `mem_read_ready` is ignored in IDLE and FETCHED.
- A request is never aborted. If `core_state` leaves FETCH while in FETCHING, the fetch still completes.
- `current_pc` changing during FETCHING has no effect, because the address is latched in IDLE.
- `enable`=0 freezes the state and every output, including an outstanding `mem_read_valid`=1.
- `reset` has priority over `enable`.
- Reset asserted mid-fetch:
  - The next edge forces IDLE with `mem_read_valid`=0.
  - A `mem_read_ready` arriving on that same edge is ignored.

## Timing

- Reset values: `fetcher_state`=000, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0.
- Request latency: `mem_read_valid` rises 1 cycle after the edge that samples FETCH in IDLE.
- Completion: `instruction` is updated and `fetcher_state`=FETCHED on the edge that samples `mem_read_ready`=1.
- Minimum uncached fetch is 2 cycles: FETCH sampled → FETCHING, then ready sampled → FETCHED.
- FETCHED → IDLE takes 1 cycle after DECODE is sampled.

## Configuration

Macro `FETCHER_CACHE_EN` adds a single-entry instruction cache.

- **Defined**
  - The cache holds a `tag` register, a `data` register and a `valid` bit; `valid` is cleared by reset.
  - Every completed memory fetch writes tag←`mem_read_address`, data←`mem_read_data`, valid←1.
  - In IDLE with `core_state`==FETCH, `valid`=1 and `current_pc`==tag: go directly to FETCHED with `instruction`←data. No memory request is made; `mem_read_valid` stays 0. Hit latency is 1 cycle.
  - A miss behaves exactly as the uncached path.
  - Program memory is read-only during a kernel, so no invalidate port exists.
- **Undefined**
  - No cache registers exist. Every FETCH issues a memory request.

## Structure

- Shared package `gpu_pkg`:
  - `core_state_t` enum (8 states, 3 bits).
  - `fetcher_state_t` enum (IDLE/FETCHING/FETCHED).
  - Default width localparams.
- Sub-module: `fetch_cache`, the single-entry tag/data/valid store with lookup and fill ports. It is instantiated only under `FETCHER_CACHE_EN`.

## Test plan

- **Reset:**
  - Stimulus: hold `reset`=0 for 2 cycles with `core_state`=FETCH.
  - Required: `fetcher_state`=000, `mem_read_valid`=0, `instruction`=0.
- **Basic fetch:**
  - Stimulus: `current_pc`=8'h0A, `core_state`=FETCH; memory returns `mem_read_ready`=1 with `mem_read_data`=16'h3145 after 3 cycles.
  - Required: `mem_read_address`=8'h0A held while valid; `instruction`=16'h3145; state FETCHED; DECODE → IDLE.
- **Address latch:**
  - Stimulus: change `current_pc` 8'h0A → 8'h20 during FETCHING.
  - Required: `mem_read_address` stays 8'h0A.
- **Enable stall:**
  - Stimulus: `enable`=0 for 4 cycles during FETCHING while `mem_read_ready` pulses.
  - Required: state and `instruction` unchanged; fetch completes after `enable`=1 and a new ready.
- **Reset mid-fetch:**
  - Stimulus: `reset`=0 in FETCHING on the same edge as `mem_read_ready`=1 with data 16'hBEEF.
  - Required: IDLE, `mem_read_valid`=0, `instruction`=0.
- **Cache (`FETCHER_CACHE_EN`):**
  - Stimulus: fetch PC 8'h05, decode, then FETCH PC 8'h05 again.
  - Required: `mem_read_valid` never rises on the second fetch; FETCHED after 1 cycle; `instruction` equals the first data.
  - Stimulus: FETCH PC 8'h06.
  - Required: a memory request is issued.
